// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition-field encodings and NZCV bit positions.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/check_condition.sv
// Evaluates an ARM condition field against the NZCV flags; undefined codes give X.
module check_condition
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  // Decode the condition code into a pass/fail decision.
  always_comb begin
    CondEx = 1'bx;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = ~z & c;
      COND_LS: CondEx = z | ~c;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'bx;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, latched execute decision,
// gating of controller write strobes and executed/skipped counters.
module cond_logic
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             CondLatch,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             InstrDone,
  input  logic             CntClr,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExReg,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       cond_ex_raw;
  logic       cond_ex;
  logic [1:0] flag_write;

  check_condition u_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex_raw)
  );

  // The undefined code never executes, which also keeps X out of CondExReg.
  assign cond_ex = (Cond == COND_NV) ? 1'b0 : cond_ex_raw;

  assign flag_write = FlagW & {2{CondExReg}};

  assign PCWrite  = NextPC | (PCS & CondExReg);
  assign RegWrite = RegW & CondExReg;
  assign MemWrite = MemW & CondExReg;

  // Capture the execute decision in Decode; holds for the rest of the instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      CondExReg <= 1'b0;
    else if (CondLatch)
      CondExReg <= cond_ex;
  end

  // N,Z and C,V halves of the flag register update independently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_write[1])
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0])
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Saturating executed/skipped counters; clear wins over a retiring instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ExecCnt <= '0;
      SkipCnt <= '0;
    end else if (CntClr) begin
      ExecCnt <= '0;
      SkipCnt <= '0;
    end else if (InstrDone) begin
      if (CondExReg) begin
        if (ExecCnt != CNT_MAX)
          ExecCnt <= ExecCnt + CNT_ONE;
      end else begin
        if (SkipCnt != CNT_MAX)
          SkipCnt <= SkipCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Randomised scoreboard bench for cond_logic against a flag/condition reference model.
module tb_cond_logic;
  localparam int CNT_W   = 4;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] Cond = '0, ALUFlags = '0;
  logic [1:0] FlagW = '0;
  logic CondLatch = 0, PCS = 0, NextPC = 0, RegW = 0, MemW = 0, InstrDone = 0, CntClr = 0;
  logic PCWrite, RegWrite, MemWrite, CondExReg;
  logic [3:0] Flags;
  logic [CNT_W-1:0] ExecCnt, SkipCnt;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .InstrDone(InstrDone), .CntClr(CntClr), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .CondExReg(CondExReg), .ExecCnt(ExecCnt),
    .SkipCnt(SkipCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pcw, rgw, mmw, cer;
    int flags, exec, skip;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model state
  bit m_n, m_z, m_c, m_v, m_cer;
  int m_exec, m_skip;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Condition codes come in pass/inverse pairs; 1110 always passes, 1111 never does.
  function automatic bit ref_cond(input int code, input bit n, input bit z, input bit c, input bit v);
    bit base;
    if (code == 14) return 1'b1;
    if (code == 15) return 1'b0;
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  function automatic int flag_word();
    return m_n * 8 + m_z * 4 + m_c * 2 + m_v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_cer = 0; m_exec = 0; m_skip = 0;
  endtask

  // One controller cycle: drive strobes, push the expected outputs, advance the model.
  task automatic step(input int cond, input int aluf, input int flagw, input bit latch,
                      input bit pcs, input bit npc, input bit regw, input bit memw,
                      input bit done, input bit clr);
    exp_t e;
    bit new_cer;
    @(posedge clk);
    #2;
    Cond = 4'(cond); ALUFlags = 4'(aluf); FlagW = 2'(flagw); CondLatch = latch;
    PCS = pcs; NextPC = npc; RegW = regw; MemW = memw; InstrDone = done; CntClr = clr;
    e.pcw = npc || (pcs && m_cer);
    e.rgw = regw && m_cer;
    e.mmw = memw && m_cer;
    e.cer = m_cer;
    e.flags = flag_word();
    e.exec = m_exec;
    e.skip = m_skip;
    exp_q.push_back(e);
    new_cer = latch ? ref_cond(cond, m_n, m_z, m_c, m_v) : m_cer;
    if ((flagw / 2) % 2 == 1 && m_cer) begin
      m_n = (aluf / 8) % 2 == 1; m_z = (aluf / 4) % 2 == 1;
    end
    if (flagw % 2 == 1 && m_cer) begin
      m_c = (aluf / 2) % 2 == 1; m_v = aluf % 2 == 1;
    end
    if (clr) begin
      m_exec = 0; m_skip = 0;
    end else if (done) begin
      if (m_cer) m_exec = (m_exec < CNT_TOP) ? m_exec + 1 : CNT_TOP;
      else       m_skip = (m_skip < CNT_TOP) ? m_skip + 1 : CNT_TOP;
    end
    m_cer = new_cer;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic quiet_inputs();
    Cond = '0; ALUFlags = '0; FlagW = '0; CondLatch = 0; PCS = 0; NextPC = 0;
    RegW = 0; MemW = 0; InstrDone = 0; CntClr = 0;
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #7;
    quiet_inputs();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_flags"}, int'(Flags), 0);
    chk({tag, "_condexreg"}, int'(CondExReg), 0);
    chk({tag, "_exec"}, int'(ExecCnt), 0);
    chk({tag, "_skip"}, int'(SkipCnt), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d cond=%h flags=%h cer=%0d pcw=%0d rgw=%0d mmw=%0d exec=%0d skip=%0d",
                 txn, Cond, Flags, CondExReg, PCWrite, RegWrite, MemWrite, ExecCnt, SkipCnt);
        chk("pcwrite", int'(PCWrite), int'(e.pcw));
        chk("regwrite", int'(RegWrite), int'(e.rgw));
        chk("memwrite", int'(MemWrite), int'(e.mmw));
        chk("condexreg", int'(CondExReg), int'(e.cer));
        chk("flags", int'(Flags), e.flags);
        chk("execcnt", int'(ExecCnt), e.exec);
        chk("skipcnt", int'(SkipCnt), e.skip);
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cycles;
    model_reset();
    #1;
    chk("por_flags", int'(Flags), 0);
    chk("por_condexreg", int'(CondExReg), 0);
    #12;
    reset_n = 1'b1;

    // EQ with Z=0 must not execute; gated strobes stay low.
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    // AL path then flag write, then EQ with Z=1.
    step(14, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 4, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    // Split flag write: set 1010, then update only C,V.
    step(0, 10, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 1, 0, 1, 0, 1, 1, 0, 0);
    idle();
    // Same-cycle hazard: clear flags, then latch EQ while writing Z.
    step(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 4, 3, 1, 0, 0, 0, 0, 0, 0);
    idle();
    // Undefined condition; NextPC still reaches PCWrite.
    step(14, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(15, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(15, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    idle();
    // Counter saturation, skip count and clear priority.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(14, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(15, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(15), $urandom_range(15), $urandom_range(3),
           $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(4) == 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
           $urandom_range(40) == 0);
      if (i == 250) begin
        idle();
        async_reset("midrun");
      end
    end
    idle();

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #6;
    chk("drain_timeout", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage of the multi-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's Cond field against it, using the check_condition sub-module.
- Registers the execute decision at Decode. All state-changing strobes from the main controller FSM (PCWrite, RegWrite, MemWrite, flag writes) are gated by that decision.
- Keeps executed/skipped instruction counters for performance debug.

Parameters:
- CNT_W, 16, width of the executed and skipped instruction counters (saturating).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Cond  in  4  Instr[31:28] of the instruction currently held in the instruction register
- ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the cycle FlagW is asserted
- FlagW  in  2  [1] = write N,Z; [0] = write C,V (from decoder)
- CondLatch  in  1  controller strobe in Decode state: capture the execute decision
- PCS  in  1  instruction writes PC (branch, or Rd==15)
- NextPC  in  1  controller unconditional PC update (Fetch)
- RegW  in  1  controller register-write request
- MemW  in  1  controller memory-write request
- InstrDone  in  1  one-cycle strobe from the controller at the last state of each instruction
- CntClr  in  1  synchronous clear of both counters
- PCWrite  out  1  gated PC enable
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- Flags  out  4  current {N,Z,C,V} register
- CondExReg  out  1  registered execute decision
- ExecCnt  out  CNT_W  executed-instruction count
- SkipCnt  out  CNT_W  skipped-instruction count

Behaviour:
- Reset (reset_n low, asynchronous): Flags=0000, CondExReg=0, ExecCnt=0, SkipCnt=0. Reset may assert at any point mid-instruction. Outputs clear immediately and do not wait for a clock edge.
- Combinational CondEx comes from check_condition(Cond, Flags).
  - Cond==4'b1111 (undefined) is forced to CondEx=0 in this block, so X never reaches any register.
- CondExReg:
  - Loads the forced CondEx on the rising edge when CondLatch=1.
  - Otherwise holds.
  - Latency from CondLatch to CondExReg valid is 1 cycle.
- Flag register:
  - FlagWrite[1] = FlagW[1] & CondExReg. When set, N,Z <= ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondExReg. When set, C,V <= ALUFlags[1:0].
  - The two halves update independently in the same cycle.
- Gated outputs (combinational, no added latency):
  - PCWrite = NextPC | (PCS & CondExReg)
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
- Simultaneous CondLatch and FlagW in the same cycle:
  - The flag update uses the old CondExReg.
  - The new CondExReg is computed from the old Flags.
  - Both are non-blocking register updates; there is no forwarding.
- Counters:
  - On InstrDone=1: ExecCnt increments if CondExReg=1, else SkipCnt increments.
  - Each counter saturates at all-ones and does not wrap.
  - CntClr=1 has priority over InstrDone: both counters go to 0 that cycle.
- The block has no internal state machine. Sequencing is owned by the controller, and this block only reacts to its strobes.

Decomposition:
- Shared package arm_pkg holds:
  - COND_* 4-bit localparams (EQ=0000 ... AL=1110, NV=1111).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module: the existing check_condition, instantiated unchanged. Its default-x case is masked here.
- Counters are inline; there is no separate counter module.

Test Plan:
1. Reset then EQ with Z=0: reset_n low mid-cycle → Flags=0000, CondExReg=0 asynchronously. Release; Cond=0000, CondLatch=1 → CondExReg=0. RegW=1, PCS=1 → RegWrite=0, PCWrite=0.
2. AL path: CondExReg=0, Cond=1110, CondLatch=1. Next cycle FlagW=11, ALUFlags=0100 → Flags=0100. The following cycle Cond=0000 with CondLatch → CondExReg=1.
3. Split flag write: Flags=1010, FlagW=01, ALUFlags=0101, CondExReg=1 → Flags=1001 (N,Z kept; C,V updated).
4. Same-cycle hazard: Flags=0000, CondExReg=1, Cond=0000 with CondLatch=1, FlagW=11, ALUFlags=0100. Next cycle → CondExReg=0 (old Z) and Flags=0100.
5. Undefined cond and NextPC: Cond=1111, CondLatch=1 → CondExReg=0. NextPC=1 → PCWrite=1; MemW=1 → MemWrite=0.
6. Counters (CNT_W=4): 15 InstrDone with CondExReg=1 → ExecCnt=15. One more → still 15. InstrDone with CondExReg=0 → SkipCnt=1. CntClr=1 together with InstrDone → both 0.
